// File: rtl/instr_prefetch.sv
// instr_prefetch: streams program bytes into a DEPTH-byte buffer and presents an opcode window
// Ports: clk, rst (sync, active-low); mem_rd/mem_addr/mem_rdata to byte-wide program memory
//        (data one cycle after the strobe); op_valid/op_code/args/op_pc opcode window to decode;
//        consume/consume_len retire the current instruction; jump/jump_target redirect fetch.
module instr_prefetch #(
    parameter int ADDR_WIDTH = 8,
    parameter int ARG_BYTES  = 2,
    parameter int DEPTH      = 4,
    parameter int LW         = $clog2(ARG_BYTES + 2)
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    mem_rd,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [7:0]              mem_rdata,
    output logic                    op_valid,
    output logic [7:0]              op_code,
    output logic [8*ARG_BYTES-1:0]  args,
    output logic [ADDR_WIDTH-1:0]   op_pc,
    input  logic                    consume,
    input  logic [LW-1:0]           consume_len,
    input  logic                    jump,
    input  logic [ADDR_WIDTH-1:0]   jump_target
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [LW-1:0] MAX_LEN = LW'(ARG_BYTES + 1);
    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;
    logic [7:0]            buffer [DEPTH];
    logic [PW-1:0]         head;
    logic [CW-1:0]         count;
    logic                  inflight;
    logic [ADDR_WIDTH-1:0] fa;
    logic [0:0]            state;
    logic [CW-1:0]         take;
    logic                  fill;
    // inflight is still counted during the cycle its data returns, so one read per cycle
    // can be issued back to back while never overrunning the buffer.
    always_comb begin
        op_valid = count >= CW'(ARG_BYTES + 1);
        take     = (consume && op_valid && !jump) ? CW'(consume_len > MAX_LEN ? MAX_LEN : consume_len) : '0;
        fill     = inflight && !jump && state == RUN;
        mem_rd   = rst && !jump && (count + CW'(inflight) < CW'(DEPTH));
        mem_addr = fa;
        op_code  = buffer[head];
        args     = '0;
        for (int i = 0; i < ARG_BYTES; i++) args[8*i +: 8] = buffer[head + PW'(i + 1)];
    end
    // The fill slot head+count is always free: a read is only issued when count+inflight < DEPTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head     <= '0;
            count    <= '0;
            inflight <= 1'b0;
            fa       <= '0;
            op_pc    <= '0;
            state    <= FLUSH;
            for (int i = 0; i < DEPTH; i++) buffer[i] <= '0;
        end else if (jump) begin
            count    <= '0;
            inflight <= 1'b0;
            fa       <= jump_target;
            op_pc    <= jump_target;
            state    <= FLUSH;
        end else begin
            if (fill) buffer[head + count[PW-1:0]] <= mem_rdata;
            head     <= head + take[PW-1:0];
            count    <= count - take + CW'(fill);
            op_pc    <= op_pc + ADDR_WIDTH'(take);
            fa       <= fa + ADDR_WIDTH'(mem_rd);
            inflight <= mem_rd;
            state    <= RUN;
        end
    end
endmodule
